conv_seq: RTL
=============

# conv_seq

Sequencer that feeds the 5x5 convolution datapath from the shared block memory. On a rising edge of iStart it reads the 25 kernel weights into the datapath weight register file, then streams 1024 packed 8-bit input pixels (32x32 image, 4 pixels per 32-bit word) one per cycle with a valid strobe. It then waits for the datapath pipeline to drain and pulses oDone. It sits between the AXI control register (start) and the convolution core plus its BRAM port.

## Interface
- ADDR_WIDTH, 12: BRAM byte-address width; the word address is ADDR_WIDTH-2 bits.
- DATA_WIDTH, 32: BRAM data width.
- WEA_WIDTH, 4: BRAM write-enable width.
- WBASE, 0: word address of weight 0.
- XBASE, 32: word address of pixel word 0.
- NUM_WORDS, 256: pixel words per image.
- PIPE_LAT, 134: drain cycles after the last pixel.
- iCLK  in  1  clock.
- iRSTn  in  1  reset, asynchronous, active-low.
- iStart  in  1  start level; a rising edge triggers a run.
- oBusy  out  1  run in progress.
- oDone  out  1  one-cycle pulse at the end of a run.
- oBlkAddr  out  ADDR_WIDTH-2  BRAM word address.
- oBlkEn  out  1  BRAM read enable.
- oBlkWe  out  WEA_WIDTH  tied to 0.
- iBlkRdata  in  DATA_WIDTH  BRAM read data, 1-cycle latency.
- oWren  out  1  weight write strobe to the datapath.
- oWADDR  out  5  weight index, 0..24.
- oW  out  32  weight word; the datapath uses bits [7:0].
- oX  out  8 signed  pixel.
- oValid  out  1  pixel valid.

## Operation
- Start detection:
  - Start condition: iStart=1 and its registered copy=0.
  - Acted on only in IDLE. Edges in any other state are ignored; a level held high does not retrigger.
- State machine: IDLE -> WLOAD -> XLOAD -> DRAIN -> IDLE.
  - IDLE: wait for the start condition.
  - WLOAD: issue 25 reads, one per cycle, address WBASE+k for k=0..24. After k=24 go to XLOAD.
  - XLOAD: issue word read j (j=0..255) at address XBASE+j, once every 4 cycles. After word 255 has been unpacked go to DRAIN.
  - DRAIN: count PIPE_LAT cycles, then pulse oDone and return to IDLE. PIPE_LAT=0 means oDone the cycle after the last pixel.
- Read data handling: data returning from read k is registered into oW. oWADDR=k and oWren=1 for exactly one cycle.
- Pixel unpacking:
  - Each returned pixel word is unpacked little-endian: byte0 first, byte3 last.
  - One pixel per cycle with oValid=1.
  - The stream is gap-free: 1024 consecutive valid cycles.
- Counters:
  - Weight index: 5 bits.
  - Word counter: 8 bits.
  - Byte select: 2 bits.
  - Addresses wrap modulo 2^(ADDR_WIDTH-2).
- oBlkEn is high only in cycles that issue a read. oBlkWe is always 0.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. No oDone is produced and no partial state is retained.

## Timing
- Reset values: oBusy, oDone, oBlkEn, oWren, oValid = 0; oBlkAddr, oWADDR, oW, oX = 0.
- Cycle 0 is the cycle in which the start condition is true.
- Weights:
  - Reads issued in cycles 1..25.
  - oWren high in cycles 3..27, with oWADDR=0..24.
  - Fixed latency of 2 cycles from issue to datapath write.
- Pixels:
  - Word j is read in cycle 26+4j.
  - Its pixels appear in cycles 28+4j .. 31+4j.
  - oValid high in cycles 28..1051. The last read is issued in cycle 1046.
- The weight load completes (cycle 27) before the first pixel (cycle 28); weight writes and pixel valids never overlap.
- Completion:
  - oDone high in cycle 1052+PIPE_LAT.
  - oBusy high in cycles 1..1052+PIPE_LAT inclusive, low the next cycle.
  - A new start edge is accepted from the cycle after oDone.

## Structure
- Package conv_pkg:
  - state enum (IDLE, WLOAD, XLOAD, DRAIN).
  - NUM_WEIGHTS=25, IMG_W=32, IMG_H=32, PIX_PER_WORD=4.
  - BRAM_RD_LAT=1.
- Sub-module conv_pix_unpack: a 32-bit load register plus a 2-bit byte selector.
  - Takes a load strobe and the read data.
  - Emits oX/oValid.
- Top-level: start edge detector, FSM, counters, address mux and weight output registers.

## Test plan
- Reset: assert iRSTn=0 at random cycles. All outputs are 0 while reset is held and in the first cycle after release.
- Weight load: BRAM words 0..24 hold 0x100+k; pulse iStart. oWren is high in cycles 3..27 with oWADDR=k and oW=0x100+k, and oBlkAddr=k in cycle k+1.
- Pixel stream: BRAM word 32+j holds {4j+3,4j+2,4j+1,4j} (mod 256). oX equals n mod 256 for pixel n in cycles 28+n, with 1024 contiguous oValid and no gaps.
- Start handling:
  - Hold iStart high for the whole run, and toggle it during XLOAD: no restart, exactly one oDone.
  - A new edge after oDone starts a second identical run.
- Reset mid-run: assert reset in cycle 500. oValid, oBusy and oBlkEn drop immediately and no oDone appears. A post-reset start gives the full sequence from weight 0.
- Completion timing: with PIPE_LAT=134, oDone is a single pulse in cycle 1186. With PIPE_LAT=0, oDone is in cycle 1052 and oBusy falls in cycle 1053.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution sequencer.
//   state_t      : sequencer FSM states
//   NUM_WEIGHTS  : kernel taps (5x5)
//   IMG_W/IMG_H  : image geometry, PIX_PER_WORD pixels packed per BRAM word
//   BRAM_RD_LAT  : block memory read latency the sequencer is built around
package conv_pkg;

  typedef enum logic [1:0] {IDLE, WLOAD, XLOAD, DRAIN} state_t;

  localparam int NUM_WEIGHTS  = 25;
  localparam int IMG_W        = 32;
  localparam int IMG_H        = 32;
  localparam int PIX_PER_WORD = 4;
  localparam int BRAM_RD_LAT  = 1;
  localparam int NUM_PIX      = IMG_W * IMG_H;

  // Little-endian byte pick: sel=0 returns bits [7:0].
  function automatic logic [7:0] pix_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[sel*8 +: 8];
  endfunction

endpackage

// File: rtl/conv_pix_unpack.sv
// conv_pix_unpack: holds one returned pixel word and emits its bytes, byte0
// first, one per cycle.
//   iCLK/iRSTn : clock, async active-low reset
//   iLoad      : iData is a pixel word to unpack (restarts at byte 0)
//   iData      : BRAM read data
//   oX/oValid  : current pixel and its strobe (oX is 0 when not valid)
//   oLast      : the byte on oX is the final byte of the held word
module conv_pix_unpack
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  iCLK,
  input  logic                  iRSTn,
  input  logic                  iLoad,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic signed [7:0]     oX,
  output logic                  oValid,
  output logic                  oLast
);

  localparam logic [1:0] LAST_SEL = 2'(PIX_PER_WORD - 1);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            sel_q, sel_d;
  logic                  vld_q, vld_d;

  // A new word lands exactly when the previous one shows its last byte, so
  // load takes priority and the stream stays gap-free.
  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    vld_d  = vld_q;
    if (iLoad) begin
      data_d = iData;
      sel_d  = '0;
      vld_d  = 1'b1;
    end else if (vld_q) begin
      sel_d = sel_q + 2'd1;
      if (sel_q == LAST_SEL) vld_d = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      data_q <= '0;
      sel_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      vld_q  <= vld_d;
    end
  end

  assign oX     = vld_q ? pix_byte(data_q[31:0], sel_q) : 8'sd0;
  assign oValid = vld_q;
  assign oLast  = vld_q && (sel_q == LAST_SEL);

endmodule

// File: rtl/conv_seq.sv
// conv_seq: sequencer for the 5x5 convolution datapath. A rising edge of
// iStart loads the 25 kernel weights, streams the packed image one pixel per
// cycle, waits PIPE_LAT cycles for the datapath to drain and pulses oDone.
//   iCLK/iRSTn     : clock, async active-low reset
//   iStart         : start level, rising edge in IDLE triggers a run
//   oBusy/oDone    : run in progress / one-cycle end-of-run pulse
//   oBlkAddr/En/We : BRAM word address, read enable, write enable (always 0)
//   iBlkRdata      : BRAM read data, one cycle after the address
//   oWren/oWADDR/oW: weight write strobe, index and word to the datapath
//   oX/oValid      : pixel stream to the datapath
module conv_seq
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int WEA_WIDTH  = 4,
  parameter int WBASE      = 0,
  parameter int XBASE      = 32,
  parameter int NUM_WORDS  = 256,
  parameter int PIPE_LAT   = 134
) (
  input  logic                  iCLK,
  input  logic                  iRSTn,
  input  logic                  iStart,
  output logic                  oBusy,
  output logic                  oDone,
  output logic [ADDR_WIDTH-3:0] oBlkAddr,
  output logic                  oBlkEn,
  output logic [WEA_WIDTH-1:0]  oBlkWe,
  input  logic [DATA_WIDTH-1:0] iBlkRdata,
  output logic                  oWren,
  output logic [4:0]            oWADDR,
  output logic [DATA_WIDTH-1:0] oW,
  output logic signed [7:0]     oX,
  output logic                  oValid
);

  localparam int            AW     = ADDR_WIDTH - 2;
  localparam int            DW     = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [DW-1:0] LAT    = DW'(PIPE_LAT);
  localparam logic [AW-1:0] WB     = AW'(WBASE);
  localparam logic [AW-1:0] XB     = AW'(XBASE);
  localparam logic [4:0]    LAST_W = 5'(NUM_WEIGHTS - 1);
  localparam logic [7:0]    LAST_X = 8'(NUM_WORDS - 1);

  state_t          state_q, state_d;
  logic            start_q, start_d;
  logic [4:0]      widx_q, widx_d;      // weight read index
  logic [7:0]      xcnt_q, xcnt_d;      // pixel word read index
  logic [1:0]      phase_q, phase_d;    // position within a 4-cycle word slot
  logic            xlast_q, xlast_d;    // final word is in the unpacker
  logic [DW-1:0]   dcnt_q, dcnt_d;      // drain counter
  // Read-return tracking: set in the cycle the BRAM data is valid.
  logic            wrd_q, wrd_d;
  logic [4:0]      wrd_idx_q, wrd_idx_d;
  logic            xrd_q, xrd_d;
  logic            xrd_last_q, xrd_last_d;
  // Weight output registers.
  logic            wren_q, wren_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] w_q, w_d;

  logic            start;
  logic            blk_en;
  logic [AW-1:0]   blk_addr;
  logic            done;
  logic            pix_last;

  assign start = iStart && !start_q;

  always_comb begin
    state_d    = state_q;
    start_d    = iStart;
    widx_d     = widx_q;
    xcnt_d     = xcnt_q;
    phase_d    = phase_q;
    xlast_d    = xlast_q;
    dcnt_d     = dcnt_q;
    wrd_d      = 1'b0;
    wrd_idx_d  = widx_q;
    xrd_d      = 1'b0;
    xrd_last_d = 1'b0;
    blk_en     = 1'b0;
    blk_addr   = '0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WLOAD;
          widx_d  = '0;
        end
      end
      WLOAD: begin
        blk_en   = 1'b1;
        blk_addr = WB + AW'(widx_q);
        wrd_d    = 1'b1;
        widx_d   = widx_q + 5'd1;
        if (widx_q == LAST_W) begin
          state_d = XLOAD;
          xcnt_d  = '0;
          phase_d = '0;
          xlast_d = 1'b0;
        end
      end
      XLOAD: begin
        phase_d = phase_q + 2'd1;
        // One word read per 4-cycle slot; xlast_q suppresses the slot that
        // follows the final word (the 8-bit counter has wrapped by then).
        if (phase_q == 2'd0 && !xlast_q) begin
          blk_en     = 1'b1;
          blk_addr   = XB + AW'(xcnt_q);
          xcnt_d     = xcnt_q + 8'd1;
          xrd_d      = 1'b1;
          xrd_last_d = (xcnt_q == LAST_X);
        end
        if (xrd_last_q) xlast_d = 1'b1;
        if (xlast_q && pix_last) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        if (dcnt_q == LAT) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Returned weight word is registered straight into the datapath port.
    wren_d  = wrd_q;
    waddr_d = wrd_q ? wrd_idx_q : waddr_q;
    w_d     = wrd_q ? iBlkRdata : w_q;
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      widx_q     <= '0;
      xcnt_q     <= '0;
      phase_q    <= '0;
      xlast_q    <= 1'b0;
      dcnt_q     <= '0;
      wrd_q      <= 1'b0;
      wrd_idx_q  <= '0;
      xrd_q      <= 1'b0;
      xrd_last_q <= 1'b0;
      wren_q     <= 1'b0;
      waddr_q    <= '0;
      w_q        <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      widx_q     <= widx_d;
      xcnt_q     <= xcnt_d;
      phase_q    <= phase_d;
      xlast_q    <= xlast_d;
      dcnt_q     <= dcnt_d;
      wrd_q      <= wrd_d;
      wrd_idx_q  <= wrd_idx_d;
      xrd_q      <= xrd_d;
      xrd_last_q <= xrd_last_d;
      wren_q     <= wren_d;
      waddr_q    <= waddr_d;
      w_q        <= w_d;
    end
  end

  conv_pix_unpack #(.DATA_WIDTH(DATA_WIDTH)) u_unpack (
    .iCLK   (iCLK),
    .iRSTn  (iRSTn),
    .iLoad  (xrd_q),
    .iData  (iBlkRdata),
    .oX     (oX),
    .oValid (oValid),
    .oLast  (pix_last)
  );

  assign oBusy    = (state_q != IDLE);
  assign oDone    = done;
  assign oBlkEn   = blk_en;
  assign oBlkAddr = blk_addr;
  assign oBlkWe   = '0;
  assign oWren    = wren_q;
  assign oWADDR   = waddr_q;
  assign oW       = w_q;

endmodule
